// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the LC-3b MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] dmem_address;
    logic [WIDTH-1:0] dmem_wdata;
    logic [1:0]       dmem_byte_enable;
    logic             dmem_read;
    logic             dmem_write;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_resp;

    modport master (
        output dmem_address, dmem_wdata, dmem_byte_enable, dmem_read, dmem_write,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_wdata, dmem_byte_enable, dmem_read, dmem_write,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: performs LDR/LDB/STR/STB/LDI/STI data accesses, retires into MEM/WB,
// publishes the EX/MEM forwarding pair and stalls the front of the pipe while busy.
module mem_access_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_mem_op,
    input  logic             in_ld_regfile,
    input  logic [2:0]       in_dest,
    input  logic [WIDTH-1:0] in_alu_out,
    input  logic [WIDTH-1:0] in_store_data,
    input  logic [WIDTH-1:0] in_pc,
    output logic             stall_out,
    output logic             fwd_valid,
    output logic [2:0]       fwd_dest,
    output logic [WIDTH-1:0] fwd_val,
    mem_access_stage_if.master dmem,
    output logic             wb_valid,
    output logic             wb_ld_regfile,
    output logic [2:0]       wb_dest,
    output logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] wb_pc
);
    localparam logic [2:0] OP_LDR = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_STR = 3'b011;
    localparam logic [2:0] OP_STB = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_STI = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic             lsb_r;
    logic [WIDTH-1:0] data_r;
    logic [2:0]       dest_r;
    logic [WIDTH-1:0] pc_r;
    logic             ld_r;
    logic             rd_r;
    logic             wr_r;
    logic [WIDTH-1:0] addr_out_r;
    logic [WIDTH-1:0] wdata_r;
    logic [1:0]       be_r;
    logic             indirect_s;

    function automatic logic is_mem_op(input logic [2:0] op);
        case (op)
            OP_LDR, OP_LDB, OP_STR, OP_STB, OP_LDI, OP_STI: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [2:0] op);
        case (op)
            OP_LDR, OP_LDB, OP_LDI: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] word_addr(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

    function automatic logic [15:0] sext_byte(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // LDB picks the addressed byte; stores retire with zero data.
    function automatic logic [15:0] load_result(input logic [2:0] op, input logic lsb,
                                                input logic [15:0] rdata);
        case (op)
            OP_LDR, OP_LDI: return rdata;
            OP_LDB:         return sext_byte(lsb ? rdata[15:8] : rdata[7:0]);
            default:        return 16'h0000;
        endcase
    endfunction

    assign indirect_s = (op_r == OP_LDI) || (op_r == OP_STI);

    assign dmem.dmem_address     = addr_out_r;
    assign dmem.dmem_wdata       = wdata_r;
    assign dmem.dmem_byte_enable = be_r;
    assign dmem.dmem_read        = rd_r;
    assign dmem.dmem_write       = wr_r;

    assign fwd_valid = in_valid & in_ld_regfile & ~is_load_op(in_mem_op);
    assign fwd_dest  = in_dest;
    assign fwd_val   = in_alu_out;

    // Stall while an access is pending; release in the cycle of the final response.
    always_comb begin
        stall_out = 1'b0;
        case (state_r)
            ST_IDLE: stall_out = in_valid & is_mem_op(in_mem_op);
            ST_ACC1: stall_out = ~(dmem.dmem_resp & ~indirect_s);
            ST_ACC2: stall_out = ~((rd_r | wr_r) & dmem.dmem_resp);
            default: stall_out = 1'b0;
        endcase
    end

    // Access FSM with registered memory request and MEM/WB outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            op_r          <= 3'b000;
            lsb_r         <= 1'b0;
            data_r        <= {WIDTH{1'b0}};
            dest_r        <= 3'b000;
            pc_r          <= {WIDTH{1'b0}};
            ld_r          <= 1'b0;
            rd_r          <= 1'b0;
            wr_r          <= 1'b0;
            addr_out_r    <= {WIDTH{1'b0}};
            wdata_r       <= {WIDTH{1'b0}};
            be_r          <= 2'b00;
            wb_valid      <= 1'b0;
            wb_ld_regfile <= 1'b0;
            wb_dest       <= 3'b000;
            wb_data       <= {WIDTH{1'b0}};
            wb_pc         <= {WIDTH{1'b0}};
        end else begin
            wb_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && is_mem_op(in_mem_op)) begin
                        op_r    <= in_mem_op;
                        lsb_r   <= in_alu_out[0];
                        data_r  <= in_store_data;
                        dest_r  <= in_dest;
                        pc_r    <= in_pc;
                        ld_r    <= in_ld_regfile;
                        state_r <= ST_ACC1;
                        case (in_mem_op)
                            OP_LDB, OP_STB: begin
                                addr_out_r <= in_alu_out;
                                be_r       <= in_alu_out[0] ? 2'b10 : 2'b01;
                                wdata_r    <= {in_store_data[7:0], in_store_data[7:0]};
                                rd_r       <= (in_mem_op == OP_LDB);
                                wr_r       <= (in_mem_op == OP_STB);
                            end
                            OP_STR: begin
                                addr_out_r <= word_addr(in_alu_out);
                                be_r       <= 2'b11;
                                wdata_r    <= in_store_data;
                                rd_r       <= 1'b0;
                                wr_r       <= 1'b1;
                            end
                            default: begin
                                // LDR, and the pointer fetch of LDI/STI
                                addr_out_r <= word_addr(in_alu_out);
                                be_r       <= 2'b11;
                                wdata_r    <= in_store_data;
                                rd_r       <= 1'b1;
                                wr_r       <= 1'b0;
                            end
                        endcase
                    end else if (in_valid) begin
                        wb_valid      <= 1'b1;
                        wb_ld_regfile <= in_ld_regfile;
                        wb_dest       <= in_dest;
                        wb_data       <= in_alu_out;
                        wb_pc         <= in_pc;
                    end
                end
                ST_ACC1: begin
                    if (dmem.dmem_resp) begin
                        rd_r <= 1'b0;
                        wr_r <= 1'b0;
                        if (indirect_s) begin
                            addr_out_r <= word_addr(dmem.dmem_rdata);
                            be_r       <= 2'b11;
                            wdata_r    <= data_r;
                            state_r    <= ST_ACC2;
                        end else begin
                            wb_valid      <= 1'b1;
                            wb_ld_regfile <= is_load_op(op_r) & ld_r;
                            wb_dest       <= dest_r;
                            wb_data       <= load_result(op_r, lsb_r, dmem.dmem_rdata);
                            wb_pc         <= pc_r;
                            state_r       <= ST_IDLE;
                        end
                    end
                end
                ST_ACC2: begin
                    if (rd_r || wr_r) begin
                        if (dmem.dmem_resp) begin
                            rd_r          <= 1'b0;
                            wr_r          <= 1'b0;
                            wb_valid      <= 1'b1;
                            wb_ld_regfile <= is_load_op(op_r) & ld_r;
                            wb_dest       <= dest_r;
                            wb_data       <= load_result(op_r, lsb_r, dmem.dmem_rdata);
                            wb_pc         <= pc_r;
                            state_r       <= ST_IDLE;
                        end
                    end else begin
                        // Pointer request was dropped for a cycle; issue the second access now.
                        rd_r <= (op_r == OP_LDI);
                        wr_r <= (op_r == OP_STI);
                    end
                end
                default: begin
                    rd_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a hand-driven data-memory responder.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_mem_op = 3'b000;
    logic        in_ld_regfile = 1'b0;
    logic [2:0]  in_dest = 3'b000;
    logic [15:0] in_alu_out = 16'h0000;
    logic [15:0] in_store_data = 16'h0000;
    logic [15:0] in_pc = 16'h0000;
    logic        stall_out, fwd_valid;
    logic [2:0]  fwd_dest;
    logic [15:0] fwd_val;
    logic        wb_valid, wb_ld_regfile;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data, wb_pc;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage_if #(.WIDTH(16)) dmem ();

    mem_access_stage #(.WIDTH(16)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_mem_op(in_mem_op), .in_ld_regfile(in_ld_regfile),
        .in_dest(in_dest), .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_pc(in_pc),
        .stall_out(stall_out), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_val(fwd_val),
        .dmem(dmem.master),
        .wb_valid(wb_valid), .wb_ld_regfile(wb_ld_regfile), .wb_dest(wb_dest),
        .wb_data(wb_data), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a memory instruction and move into the first access cycle.
    task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] dest,
                         input logic [15:0] alu, input logic [15:0] sdata, input logic [15:0] pc);
        in_valid = 1'b1; in_mem_op = op; in_ld_regfile = (op == 3'b001 || op == 3'b010 || op == 3'b101);
        in_dest = dest; in_alu_out = alu; in_store_data = sdata; in_pc = pc;
        #1;
        check_eq({tag, "_issue_stall"}, {15'd0, stall_out}, 16'd1);
        check_eq({tag, "_fwd_valid"}, {15'd0, fwd_valid}, 16'd0);
        tick();
    endtask

    // Wait for a request, check it, answer after lat cycles.
    task automatic serve(input string tag, input logic exp_wr, input logic [15:0] exp_addr,
                         input logic [1:0] exp_be, input logic [15:0] exp_wdata,
                         input logic [15:0] rdata, input int lat, input logic last);
        int w = 0;
        while (!(dmem.dmem_read || dmem.dmem_write) && w < 8) begin
            tick();
            w++;
        end
        check_eq({tag, "_req"}, {15'd0, dmem.dmem_read | dmem.dmem_write}, 16'd1);
        check_eq({tag, "_wr"}, {14'd0, dmem.dmem_write, dmem.dmem_read}, {14'd0, exp_wr, ~exp_wr});
        check_eq({tag, "_addr"}, dmem.dmem_address, exp_addr);
        check_eq({tag, "_be"}, {14'd0, dmem.dmem_byte_enable}, {14'd0, exp_be});
        if (exp_wr) check_eq({tag, "_wdata"}, dmem.dmem_wdata, exp_wdata);
        for (int i = 0; i < lat; i++) begin
            check_eq({tag, "_wait_stall"}, {15'd0, stall_out}, 16'd1);
            tick();
        end
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = rdata;
        #1;
        check_eq({tag, "_resp_stall"}, {15'd0, stall_out}, {15'd0, ~last});
        tick();
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = 16'h0000;
        if (last) in_valid = 1'b0;
        check_eq({tag, "_req_drop"}, {15'd0, dmem.dmem_read | dmem.dmem_write}, 16'd0);
    endtask

    task automatic expect_retire(input string tag, input logic ld, input logic [2:0] dest,
                                 input logic [15:0] data, input logic [15:0] pc);
        check_eq({tag, "_wb_valid"}, {15'd0, wb_valid}, 16'd1);
        check_eq({tag, "_wb_ld"}, {15'd0, wb_ld_regfile}, {15'd0, ld});
        check_eq({tag, "_wb_dest"}, {13'd0, wb_dest}, {13'd0, dest});
        check_eq({tag, "_wb_data"}, wb_data, data);
        check_eq({tag, "_wb_pc"}, wb_pc, pc);
        tick();
        check_eq({tag, "_wb_pulse"}, {15'd0, wb_valid}, 16'd0);
    endtask

    initial begin
        dmem.dmem_resp = 1'b0;
        dmem.dmem_rdata = 16'h0000;
        tick();
        tick();
        check_eq("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        check_eq("rst_wb_data", wb_data, 16'h0000);
        check_eq("rst_req", {15'd0, dmem.dmem_read | dmem.dmem_write}, 16'd0);
        check_eq("rst_stall", {15'd0, stall_out}, 16'd0);
        rst = 1'b0;
        tick();

        // ADD R3 = 0x0042: single-cycle retire, no stall
        in_valid = 1'b1; in_mem_op = 3'b000; in_ld_regfile = 1'b1; in_dest = 3'd3;
        in_alu_out = 16'h0042; in_pc = 16'h3000;
        #1;
        check_eq("add_stall", {15'd0, stall_out}, 16'd0);
        check_eq("add_fwd_valid", {15'd0, fwd_valid}, 16'd1);
        check_eq("add_fwd_val", fwd_val, 16'h0042);
        check_eq("add_fwd_dest", {13'd0, fwd_dest}, 16'd3);
        tick();
        in_valid = 1'b0;
        expect_retire("add", 1'b1, 3'd3, 16'h0042, 16'h3000);

        // op 111 is also a non-memory instruction
        in_valid = 1'b1; in_mem_op = 3'b111; in_ld_regfile = 1'b1; in_dest = 3'd5;
        in_alu_out = 16'h8001; in_pc = 16'h3002;
        #1;
        check_eq("op7_stall", {15'd0, stall_out}, 16'd0);
        tick();
        in_valid = 1'b0;
        expect_retire("op7", 1'b1, 3'd5, 16'h8001, 16'h3002);

        // stray response while idle is ignored
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'hDEAD;
        tick();
        dmem.dmem_resp = 1'b0;
        check_eq("idle_resp_wb", {15'd0, wb_valid}, 16'd0);
        check_eq("idle_resp_req", {15'd0, dmem.dmem_read | dmem.dmem_write}, 16'd0);

        issue("ldr", 3'b001, 3'd1, 16'h1005, 16'h0000, 16'h3010);
        serve("ldr", 1'b0, 16'h1004, 2'b11, 16'h0000, 16'hBEEF, 3, 1'b1);
        expect_retire("ldr", 1'b1, 3'd1, 16'hBEEF, 16'h3010);

        issue("ldb_hi", 3'b010, 3'd2, 16'h2001, 16'h0000, 16'h3012);
        serve("ldb_hi", 1'b0, 16'h2001, 2'b10, 16'h0000, 16'h80AA, 1, 1'b1);
        expect_retire("ldb_hi", 1'b1, 3'd2, 16'hFF80, 16'h3012);

        issue("ldb_lo", 3'b010, 3'd4, 16'h2000, 16'h0000, 16'h3014);
        serve("ldb_lo", 1'b0, 16'h2000, 2'b01, 16'h0000, 16'h80AA, 0, 1'b1);
        expect_retire("ldb_lo", 1'b1, 3'd4, 16'hFFAA, 16'h3014);

        issue("stb", 3'b100, 3'd0, 16'h3000, 16'h12CD, 16'h3016);
        serve("stb", 1'b1, 16'h3000, 2'b01, 16'hCDCD, 16'h0000, 2, 1'b1);
        expect_retire("stb", 1'b0, 3'd0, 16'h0000, 16'h3016);

        issue("str", 3'b011, 3'd6, 16'h6003, 16'h5A5A, 16'h3018);
        serve("str", 1'b1, 16'h6002, 2'b11, 16'h5A5A, 16'h0000, 1, 1'b1);
        expect_retire("str", 1'b0, 3'd6, 16'h0000, 16'h3018);

        issue("ldi", 3'b101, 3'd7, 16'h4000, 16'h0000, 16'h301A);
        serve("ldi_ptr", 1'b0, 16'h4000, 2'b11, 16'h0000, 16'h5002, 1, 1'b0);
        check_eq("ldi_gap_stall", {15'd0, stall_out}, 16'd1);
        serve("ldi_dat", 1'b0, 16'h5002, 2'b11, 16'h0000, 16'h1234, 1, 1'b1);
        expect_retire("ldi", 1'b1, 3'd7, 16'h1234, 16'h301A);

        issue("sti", 3'b110, 3'd3, 16'h4000, 16'hAAAA, 16'h301C);
        serve("sti_ptr", 1'b0, 16'h4000, 2'b11, 16'h0000, 16'h5002, 0, 1'b0);
        serve("sti_dat", 1'b1, 16'h5002, 2'b11, 16'hAAAA, 16'h0000, 2, 1'b1);
        expect_retire("sti", 1'b0, 3'd3, 16'h0000, 16'h301C);

        // reset in the middle of an LDR aborts it without a retire
        issue("rst_ldr", 3'b001, 3'd1, 16'h1005, 16'h0000, 16'h3020);
        check_eq("rst_ldr_read", {15'd0, dmem.dmem_read}, 16'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rst_ldr_drop", {15'd0, dmem.dmem_read}, 16'd0);
        check_eq("rst_ldr_wb", {15'd0, wb_valid}, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_ldr_no_wb", {15'd0, wb_valid}, 16'd0);
        check_eq("rst_ldr_idle", {15'd0, dmem.dmem_read | stall_out}, 16'd0);

        issue("ldr2", 3'b001, 3'd2, 16'h1006, 16'h0000, 16'h3022);
        serve("ldr2", 1'b0, 16'h1006, 2'b11, 16'h0000, 16'h7777, 1, 1'b1);
        expect_retire("ldr2", 1'b1, 3'd2, 16'h7777, 16'h3022);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
